// File: rtl/mydpram_pkg.sv
// Shared types and helpers for the self-clearing dual-port RAM.
// Lane merge is sized to a wide maximum; callers slice to their width.
package mydpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int LANEBITS = 8;
  localparam int MAXBITS  = 1024;
  localparam int MAXLANES = MAXBITS / LANEBITS;

  function automatic logic [MAXBITS-1:0] lane_merge(
    input logic [MAXBITS-1:0]  old_w,
    input logic [MAXBITS-1:0]  new_w,
    input logic [MAXLANES-1:0] mask
  );
    logic [MAXBITS-1:0] r;
    r = old_w;
    for (int i = 0; i < MAXLANES; i++) begin
      if (mask[i])
        r[i*LANEBITS +: LANEBITS] = new_w[i*LANEBITS +: LANEBITS];
    end
    return r;
  endfunction

endpackage

// File: rtl/mydpram_clrseq.sv
// Post-reset clear sequencer: walks every entry once, then
// parks in ST_RUN until the next reset.
module mydpram_clrseq
  import mydpram_pkg::*;
#(
  parameter int ADDRBITS = 5,
  parameter int MEMSIZE  = 2**ADDRBITS
) (
  input  logic                clk,
  input  logic                reset,
  output logic                busy,
  output logic                clr_we,
  output logic [ADDRBITS-1:0] clr_addr
);

  localparam logic [ADDRBITS-1:0] LAST = ADDRBITS'(MEMSIZE - 1);

  state_t              state;
  logic [ADDRBITS-1:0] clrcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_CLEAR;
      clrcnt <= '0;
      busy   <= 1'b1;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          if (clrcnt == LAST) begin
            state  <= ST_RUN;
            clrcnt <= '0;
            busy   <= 1'b0;
          end else begin
            clrcnt <= clrcnt + 1'b1;
          end
        end
        ST_RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = clrcnt;

endmodule

// File: rtl/mydpram_clr.sv
// Simple dual-port RAM with byte enables, optional registered read,
// read-during-write bypass and a self-clearing fill after reset.
module mydpram_clr
  import mydpram_pkg::*;
#(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 5,
  parameter int MEMSIZE  = 2**ADDRBITS,
  localparam int MASKBITS = DATABITS / LANEBITS,
  parameter int RDREG    = 1,
  parameter int BYPASS   = 1,
  parameter logic [DATABITS-1:0] CLRVAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] wraddr,
  input  logic                we,
  input  logic [MASKBITS-1:0] wrmask,
  input  logic [DATABITS-1:0] in,
  input  logic [ADDRBITS-1:0] rdaddr,
  input  logic                re,
  output logic [DATABITS-1:0] q,
  output logic                q_valid,
  output logic                busy
);

  localparam logic [ADDRBITS:0] LIMIT = (ADDRBITS+1)'(MEMSIZE);

  logic [DATABITS-1:0] remember [MEMSIZE];

  logic                clr_we;
  logic [ADDRBITS-1:0] clr_addr;
  logic                wr_in;
  logic                rd_in;
  logic                wr_ok;
  logic [DATABITS-1:0] wr_cur;
  logic [DATABITS-1:0] rd_old;

  function automatic logic [DATABITS-1:0] merge(
    input logic [DATABITS-1:0] old_w,
    input logic [DATABITS-1:0] new_w,
    input logic [MASKBITS-1:0] mask
  );
    logic [MAXBITS-1:0]  o;
    logic [MAXBITS-1:0]  n;
    logic [MAXBITS-1:0]  r;
    logic [MAXLANES-1:0] m;
    o = '0;
    n = '0;
    m = '0;
    o[DATABITS-1:0] = old_w;
    n[DATABITS-1:0] = new_w;
    m[MASKBITS-1:0] = mask;
    r = lane_merge(o, n, m);
    return r[DATABITS-1:0];
  endfunction

  mydpram_clrseq #(
    .ADDRBITS (ADDRBITS),
    .MEMSIZE  (MEMSIZE)
  ) u_clrseq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_in  = ({1'b0, wraddr} < LIMIT);
  assign rd_in  = ({1'b0, rdaddr} < LIMIT);
  assign wr_ok  = we && !busy && wr_in && (|wrmask);
  assign wr_cur = wr_in ? remember[wraddr] : '0;
  assign rd_old = rd_in ? remember[rdaddr] : '0;

  // Clear writes take priority; user writes are ignored while busy.
  always_ff @(posedge clk) begin
    if (clr_we)
      remember[clr_addr] <= CLRVAL;
    else if (wr_ok)
      remember[wraddr] <= merge(wr_cur, in, wrmask);
  end

  if (RDREG != 0) begin : g_reg
    logic                rd_hit;
    logic [DATABITS-1:0] rd_word;

    assign rd_hit  = (BYPASS != 0) && wr_ok && (wraddr == rdaddr);
    assign rd_word = rd_hit ? merge(rd_old, in, wrmask) : rd_old;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q       <= '0;
        q_valid <= 1'b0;
      end else begin
        q_valid <= re && !busy;
        if (re && !busy)
          q <= rd_word;
      end
    end
  end else begin : g_comb
    assign q       = rd_old;
    assign q_valid = !busy;
  end

endmodule
